// File: rtl/eb_rr_arb_if.sv
// eb_rr_arb handshake bundle.
// N requesters on the t_* side, one downstream channel on the i_* side.
interface eb_rr_arb_if #(
  parameter int W  = 32,
  parameter int N  = 4,
  parameter int SW = 2
);
  logic [N*W-1:0] t_dat;
  logic [N-1:0]   t_last;
  logic [N-1:0]   t_req;
  logic [N-1:0]   t_ack;
  logic [W-1:0]   i_dat;
  logic           i_last;
  logic           i_req;
  logic           i_ack;
  logic [SW-1:0]  i_sel;
  logic           busy;

  modport slave (
    input  t_dat, t_last, t_req, i_ack,
    output t_ack, i_dat, i_last, i_req, i_sel, busy
  );

  modport master (
    output t_dat, t_last, t_req, i_ack,
    input  t_ack, i_dat, i_last, i_req, i_sel, busy
  );
endinterface

// File: rtl/eb_rr_arb.sv
// eb_rr_arb: packet-locked round-robin arbiter.
// One idle cycle per packet picks the next port; grant held until last.
module eb_rr_arb #(
  parameter int W  = 32,
  parameter int N  = 4,
  parameter int SW = 2
) (
  input logic          clk,
  input logic          reset_n,
  eb_rr_arb_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [SW-1:0] g;
  logic [SW-1:0] ptr;
  logic [SW-1:0] pick;
  logic          held;
  logic          xfer;
  logic [SW-1:0] nxt_ptr;

  // first requester at or after ptr, wrapping at N-1
  always_comb begin
    logic          found;
    int            idx;
    logic [SW-1:0] k;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      k = SW'(idx);
      if (!found && bus.t_req[k]) begin
        found = 1'b1;
        pick  = k;
      end
    end
  end

  // forwarding of the granted port and ack steering
  always_comb begin
    held       = (state == GRANT);
    bus.busy   = held;
    bus.i_sel  = g;
    bus.i_dat  = bus.t_dat[g*W +: W];
    bus.i_req  = held & bus.t_req[g];
    bus.i_last = held & bus.t_req[g] & bus.t_last[g];
    bus.t_ack  = '0;
    if (held && bus.i_ack) bus.t_ack = N'(1) << g;
    xfer       = held & bus.t_req[g] & bus.i_ack;
    nxt_ptr    = (g == SW'(N - 1)) ? '0 : g + SW'(1);
  end

  // arbitration and packet lock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.t_req) begin
            g     <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (xfer && bus.t_last[g]) begin
            ptr   <= nxt_ptr;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eb_rr_arb.sv
// Randomised scoreboard bench for eb_rr_arb.
// Packet-level reference model; monitor checks every downstream beat.
module tb_eb_rr_arb;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  eb_rr_arb_if #(.W(W), .N(N), .SW(SW)) bus ();
  eb_rr_arb_if #(.W(W), .N(3), .SW(2)) bus3 ();

  eb_rr_arb #(.W(W), .N(N), .SW(SW)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  eb_rr_arb #(.W(W), .N(3), .SW(2)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    int           p;
  } beat_t;

  beat_t        expq[$];
  logic [W:0]   pkt[N][$];
  int           grant_log[$];
  logic [N-1:0] req_r;
  int           lock;
  int           ptr;
  int           checks;
  int           failures;
  int           new_pct, req_pct, ack_pct, maxlen;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // requester side: keep req and data stable until acked
  task automatic drive();
    for (int p = 0; p < N; p++) begin
      if (pkt[p].size() == 0 && $urandom_range(0, 99) < new_pct) begin
        int len;
        len = $urandom_range(1, maxlen);
        for (int b = 0; b < len; b++)
          pkt[p].push_back({(b == len - 1), W'($urandom)});
      end
      if (!req_r[p] && pkt[p].size() != 0 &&
          $urandom_range(0, 99) < req_pct)
        req_r[p] = 1'b1;
      if (pkt[p].size() != 0) begin
        bus.t_dat[p*W +: W] = pkt[p][0][W-1:0];
        bus.t_last[p]       = pkt[p][0][W];
      end else begin
        bus.t_dat[p*W +: W] = W'($urandom);
        bus.t_last[p]       = 1'($urandom_range(0, 1));
      end
    end
    bus.t_req = req_r;
    bus.i_ack = ($urandom_range(0, 99) < ack_pct);
  endtask

  // reference model step, taken mid-cycle on settled values
  task automatic observe();
    logic [N-1:0] ta;
    logic [N-1:0] rq;
    ta = bus.t_ack;
    rq = bus.t_req;
    if (!reset_n) begin
      chk("rst_ack", 64'(ta), 0);
      chk("rst_ireq", 64'(bus.i_req), 0);
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_sel", 64'(bus.i_sel), 0);
      chk("rst_dat", 64'(bus.i_dat), 64'(bus.t_dat[W-1:0]));
      return;
    end
    if (lock < 0) begin
      chk("idle_busy", 64'(bus.busy), 0);
      chk("idle_ack", 64'(ta), 0);
      if (rq != 0) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (ptr + i) % N;
          if (lock < 0 && rq[k]) lock = k;
        end
        foreach (pkt[lock][b])
          expq.push_back('{pkt[lock][b][W-1:0], pkt[lock][b][W], lock});
      end
    end else begin
      chk("grant_busy", 64'(bus.busy), 1);
      chk("grant_ireq", 64'(bus.i_req), 64'(rq[lock]));
      if (rq[lock] && bus.i_ack && pkt[lock].size() != 0 &&
          pkt[lock][0][W]) begin
        ptr  = (lock + 1) % N;
        lock = -1;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (ta[p] && rq[p] && pkt[p].size() != 0) begin
        void'(pkt[p].pop_front());
        req_r[p] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  // downstream monitor: pops one expected beat per transfer
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        logic [N-1:0] ea;
        ea = '0;
        if (bus.busy && bus.i_ack) ea = N'(1) << bus.i_sel;
        chk("mon_tack", 64'(bus.t_ack), 64'(ea));
        if (bus.i_req && bus.i_ack) begin
          if (expq.size() == 0) begin
            chk("mon_unexpected", 64'(bus.i_dat), 64'hdead);
          end else begin
            beat_t e;
            e = expq.pop_front();
            chk("mon_dat", 64'(bus.i_dat), 64'(e.d));
            chk("mon_last", 64'(bus.i_last), 64'(e.l));
            chk("mon_sel", 64'(bus.i_sel), 64'(e.p));
            grant_log.push_back(int'(bus.i_sel));
          end
        end
      end
    end
  end

  initial begin
    int rot[6];
    int n;
    rot = '{0, 1, 2, 3, 0, 1};
    checks = 0; failures = 0;
    lock = -1; ptr = 0; req_r = '0;
    bus.t_dat = '0; bus.t_last = '0; bus.t_req = '0; bus.i_ack = 1'b0;
    bus3.t_dat = '0; bus3.t_last = '0; bus3.t_req = '0;
    bus3.i_ack = 1'b0;
    new_pct = 100; req_pct = 100; ack_pct = 100; maxlen = 1;

    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) cycle();
    chk("rot_count", 64'(grant_log.size() >= 6), 1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("rot_order", 64'(grant_log[i]), 64'(rot[i]));

    new_pct = 30; req_pct = 70; ack_pct = 60; maxlen = 4;
    for (int i = 0; i < 3000; i++) cycle();

    n = 0;
    while (!(lock >= 0 && bus.busy) && n < 200) begin
      cycle();
      n++;
    end
    chk("midrst_found", 64'(n < 200), 1);
    drive();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_ack", 64'(bus.t_ack), 0);
    chk("midrst_busy", 64'(bus.busy), 0);
    chk("midrst_ireq", 64'(bus.i_req), 0);
    chk("midrst_sel", 64'(bus.i_sel), 0);
    lock = -1; ptr = 0; req_r = '0;
    expq.delete();
    for (int p = 0; p < N; p++) pkt[p].delete();
    @(posedge clk); #1;
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 500; i++) cycle();

    new_pct = 0; req_pct = 100; ack_pct = 100;
    for (int i = 0; i < 200; i++) cycle();
    chk("drain_expq", 64'(expq.size()), 0);
    n = 0;
    for (int p = 0; p < N; p++) n += pkt[p].size();
    chk("drain_pkts", 64'(n), 0);

    bus.t_req = '0;
    bus3.t_dat = {32'hc2, 32'hc1, 32'hc0};
    bus3.t_last = 3'b111;
    bus3.t_req = 3'b100;
    bus3.i_ack = 1'b1;
    @(negedge clk);
    chk("n3_idle", 64'(bus3.busy), 0);
    @(negedge clk);
    chk("n3_sel2", 64'(bus3.i_sel), 2);
    chk("n3_ack2", 64'(bus3.t_ack), 64'b100);
    chk("n3_dat2", 64'(bus3.i_dat), 64'hc2);
    @(posedge clk); #1;
    bus3.t_req = 3'b111;
    @(negedge clk);
    chk("n3_idle2", 64'(bus3.busy), 0);
    @(negedge clk);
    chk("n3_wrap", 64'(bus3.i_sel), 0);
    chk("n3_dat0", 64'(bus3.i_dat), 64'hc0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eb_rr_arb.md
Name: eb_rr_arb

Overview:
Round-robin arbiter that shares one downstream req/ack elastic channel between N upstream req/ack requesters. It is used in front of an elastic buffer stage when several producers feed one consumer. Grants are packet-locked: once a port wins, it keeps the channel until it transfers a beat flagged last. The grant is registered, so there is no combinational path from any t_req to the grant decision.

Parameters:
W, 32, data width per port
N, 4, number of requester ports (2..16)
SW, 2, width of grant index; must equal clog2(N), minimum 1

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
t_dat  input  N*W  requester data; port k occupies bits [k*W +: W]
t_last  input  N  per-port last-beat-of-packet flag, qualified by t_req
t_req  input  N  per-port request (valid)
t_ack  output  N  per-port acknowledge (ready)
i_dat  output  W  data to downstream
i_last  output  1  last flag to downstream
i_req  output  1  request to downstream
i_ack  input  1  acknowledge from downstream
i_sel  output  SW  index of currently granted port
busy  output  1  high while a grant is held

Behaviour:
- Transfer on any channel = req & ack high in the same cycle. A requester holds req and data stable until acked. Between beats it may drop req; the lock is kept.
- State: IDLE, GRANT. Registers: state, g (grant index, SW bits), ptr (priority pointer, SW bits).
- Reset (asynchronous, any time including mid-packet):
  - state=IDLE, g=0, ptr=0.
  - Outputs immediately: i_req=0, i_last=0, t_ack=0, busy=0, i_sel=0, i_dat=t_dat slice 0.
- IDLE:
  - i_req=0, i_last=0, t_ack=0, busy=0. No transfer is possible.
  - If any t_req is high, g <= first port k with t_req[k]=1, searching k=ptr, ptr+1, ..., N-1, 0, ..., ptr-1. State <= GRANT.
  - If no request, hold.
- GRANT:
  - busy=1, i_sel=g, i_dat=t_dat slice g, i_last=t_last[g]&t_req[g], i_req=t_req[g].
  - t_ack[g]=i_ack. All other t_ack bits are 0.
  - These paths are combinational: one-cycle-free forwarding, and i_ack to t_ack is combinational.
  - On a transfer with t_last[g]=1: ptr <= (g==N-1) ? 0 : g+1, and state <= IDLE.
  - On a transfer without last: stay in GRANT.
  - No transfer: stay.
- Arbitration costs one idle cycle per packet. An L-beat packet with i_ack held high occupies exactly L+1 cycles, IDLE included.
- Requests on non-granted ports are ignored (acks 0) and are evaluated again in the next IDLE cycle.
- Fairness: after port k completes a packet, port k has lowest priority in the next arbitration. With all N ports requesting continuously, grants rotate 0,1,...,N-1,0,...
- Non-power-of-2 N: ptr and the search wrap at N-1 to 0. Index values >= N never occur.
- i_ack high while i_req low has no effect.
- A t_last on a non-granted port has no effect.

Test Plan:
- Reset/idle: hold reset_n=0, drive t_req=4'b1111 -> t_ack=0, i_req=0, busy=0. Release reset -> first grant g=0 after one cycle, i_sel=0.
- Single packet: port 2 sends 3 beats (D0,D1,D2=last) with i_ack=1 -> i_dat shows D0,D1,D2 on consecutive cycles starting cycle 2. t_ack[2] is high on those 3 cycles only. busy drops on cycle 5. ptr=3.
- Rotation: all 4 ports send continuous 1-beat packets, i_ack=1 -> grant order 0,1,2,3,0,1. One transfer every 2 cycles.
- Lock under contention: port 1 sends a 4-beat packet while port 0 requests throughout -> port 0 gets t_ack=0 until port 1's last beat. Next grant is port 2 if port 2 requests, otherwise port 0.
- Backpressure and gaps: port 3 granted, i_ack toggles 1,0,0,1 and t_req[3] drops for one cycle mid-packet -> beats are accepted only on req&ack cycles, no data loss, grant held until last.
- Reset mid-packet, and N=3 wrap: assert reset_n=0 during beat 2 of a packet -> next cycle state IDLE, all t_ack=0. With N=3, port 2 finishing -> ptr=0.
